// File: rtl/digi_lock_pkg.sv
// rtl/digi_lock_pkg.sv - shared types and defaults for the digital lock key path
package digi_lock_pkg;

  localparam int SYM_W_DEF   = 3;
  localparam int NUM_SYM_DEF = 3;
  localparam int TIMEOUT_DEF = 15;
  localparam logic [SYM_W_DEF*NUM_SYM_DEF-1:0] CODE_DEF = 9'b001_101_011;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND        = 3'd1,
    WAIT_UNLOCK = 3'd2,
    DONE        = 3'd3,
    FAIL        = 3'd4
  } state_t;

endpackage

// File: rtl/digi_timeout_cnt.sv
// rtl/digi_timeout_cnt.sv - clear/enable saturating wait counter with terminal count
module digi_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && count != CNT_W'(TIMEOUT)) begin
      count <= count + 1'b1;
    end
  end

  // tc marks the last cycle a wait may last before the timeout edge
  assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/digi_key_tx.sv
// rtl/digi_key_tx.sv - sends the stored unlock code symbol by symbol and reports the lock result
module digi_key_tx
  import digi_lock_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int NUM_SYM = NUM_SYM_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter logic [SYM_W*NUM_SYM-1:0] CODE = CODE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     code_load,
  input  logic [SYM_W*NUM_SYM-1:0] code_in,
  output logic [SYM_W-1:0]         key_out,
  output logic                     key_valid,
  input  logic                     key_ack,
  input  logic                     unlocked,
  output logic                     busy,
  output logic                     done,
  output logic                     fail
);

  localparam int CW    = SYM_W * NUM_SYM;
  localparam int IDX_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    code;
  logic             tmo_clr;
  logic             tmo_tc;

  function automatic logic [SYM_W-1:0] sym_at(input logic [CW-1:0] c, input int i);
    logic [CW-1:0] s;
    s = c >> ((NUM_SYM - 1 - i) * SYM_W);
    return s[SYM_W-1:0];
  endfunction

  // The wait counter restarts on entry to SEND and after every accepted symbol,
  // so WAIT_UNLOCK begins counting from zero.
  assign tmo_clr = !(state == SEND || state == WAIT_UNLOCK) ||
                   (state == SEND && key_valid && key_ack);

  digi_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (1'b1),
    .tc  (tmo_tc)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      code      <= CODE;
      key_out   <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        IDLE: begin
          if (code_load) code <= code_in;
          if (start) begin
            idx       <= '0;
            key_valid <= 1'b1;
            key_out   <= sym_at(code_load ? code_in : code, 0);
            state     <= SEND;
          end
        end
        SEND: begin
          if (key_ack) begin
            if (idx == IDX_W'(NUM_SYM - 1)) begin
              key_valid <= 1'b0;
              state     <= WAIT_UNLOCK;
            end else begin
              idx     <= idx + 1'b1;
              key_out <= sym_at(code, int'(idx) + 1);
            end
          end else if (tmo_tc) begin
            key_valid <= 1'b0;
            fail      <= 1'b1;
            state     <= FAIL;
          end
        end
        WAIT_UNLOCK: begin
          if (unlocked) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (tmo_tc) begin
            fail  <= 1'b1;
            state <= FAIL;
          end
        end
        DONE, FAIL: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digi_key_tx.sv
// tb/tb_digi_key_tx.sv - randomized transaction-level bench for digi_key_tx
module tb_digi_key_tx;

  localparam int SYM_W   = 3;
  localparam int NUM_SYM = 3;
  localparam int TIMEOUT = 15;
  localparam logic [8:0] RESET_CODE = 9'b001_101_011;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       code_load;
  logic [8:0] code_in;
  logic [2:0] key_out;
  logic       key_valid;
  logic       key_ack;
  logic       unlocked;
  logic       busy;
  logic       done;
  logic       fail;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] model_code;

  digi_key_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .code_load (code_load),
    .code_in   (code_in),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .unlocked  (unlocked),
    .busy      (busy),
    .done      (done),
    .fail      (fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [2:0] sym(input logic [8:0] c, input int k);
    return c[(NUM_SYM - 1 - k) * SYM_W +: SYM_W];
  endfunction

  // One transaction: ack delay per symbol (>=TIMEOUT means never acked) and the
  // WAIT_UNLOCK cycle on which unlocked rises (>=TIMEOUT means never).
  task automatic run(input bit load, input logic [8:0] cin, input int a0, input int a1,
                     input int a2, input int u, input bit disturb);
    int acks[3];
    int fail_sym;
    int hold;
    int wlen;
    logic [8:0] c;
    acks = '{a0, a1, a2};
    if (load) model_code = cin;
    c = model_code;
    fail_sym = NUM_SYM;
    for (int k = NUM_SYM - 1; k >= 0; k--) if (acks[k] >= TIMEOUT) fail_sym = k;

    check("idle_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; code_load = load; code_in = cin;
    @(negedge clk);
    start = 1'b0; code_load = 1'b0;

    for (int k = 0; k < NUM_SYM && k <= fail_sym; k++) begin
      hold = (k == fail_sym) ? TIMEOUT : acks[k] + 1;
      for (int t = 0; t < hold; t++) begin
        check("key_valid", {31'b0, key_valid}, 32'd1);
        check($sformatf("key_out_s%0d", k), {29'b0, key_out}, {29'b0, sym(c, k)});
        check("send_busy", {31'b0, busy}, 32'd1);
        check("send_pulses", {30'b0, done, fail}, 32'd0);
        if (disturb && k == 0 && t == 0) begin
          start = 1'b1; code_load = 1'b1; code_in = 9'b0;
        end
        key_ack = (k != fail_sym) && (t == hold - 1);
        @(negedge clk);
        start = 1'b0; code_load = 1'b0; key_ack = 1'b0;
      end
    end

    if (fail_sym < NUM_SYM) begin
      check("ack_tmo_fail", {31'b0, fail}, 32'd1);
      check("ack_tmo_done", {31'b0, done}, 32'd0);
      check("ack_tmo_valid", {31'b0, key_valid}, 32'd0);
    end else begin
      wlen = (u < TIMEOUT) ? u + 1 : TIMEOUT;
      for (int t = 0; t < wlen; t++) begin
        check("wait_valid", {31'b0, key_valid}, 32'd0);
        check("wait_busy", {31'b0, busy}, 32'd1);
        check("wait_pulses", {30'b0, done, fail}, 32'd0);
        unlocked = (t == u);
        @(negedge clk);
        unlocked = 1'b0;
      end
      check("result_done", {31'b0, done}, {31'b0, u < TIMEOUT});
      check("result_fail", {31'b0, fail}, {31'b0, u >= TIMEOUT});
    end
    @(negedge clk);
    check("end_pulses", {30'b0, done, fail}, 32'd0);
    check("end_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; code_load = 1'b0; code_in = 9'b0;
    key_ack = 1'b0; unlocked = 1'b0;
    model_code = RESET_CODE;
    @(negedge clk);
    @(negedge clk);
    check("rst_key_out", {29'b0, key_out}, 32'd0);
    check("rst_outputs", {28'b0, key_valid, busy, done, fail}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 9'b0, 0, 0, 0, 2, 0);
    run(0, 9'b0, 0, 1, 2, 3, 1);
    run(0, 9'b0, 0, 0, 0, 0, 0);
    run(1, 9'b111_000_010, 3, 3, 3, 1, 0);
    run(0, 9'b0, TIMEOUT, 0, 0, 0, 0);
    run(0, 9'b0, 0, 0, 0, TIMEOUT, 0);
    run(0, 9'b0, 0, 0, 0, TIMEOUT - 1, 0);
    run(0, 9'b0, TIMEOUT - 1, 0, 0, 0, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("pre_rst_sym1", {29'b0, key_out}, {29'b0, sym(model_code, 1)});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_code = RESET_CODE;
    check("abort_outputs", {28'b0, key_valid, busy, done, fail}, 32'd0);
    @(negedge clk);
    check("abort_no_pulse", {30'b0, done, fail}, 32'd0);
    run(0, 9'b0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      int a[3];
      for (int k = 0; k < 3; k++)
        a[k] = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
      run(1'($urandom_range(0, 1)), 9'($urandom), a[0], a[1], a[2],
          int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
